// File: rtl/i2s_rx_multi.sv
// I2S microphone receiver: bclk/lrclk generation, 1/2-channel capture, output FIFO.
// Optional DC-offset removal is compiled in with I2S_RX_DC_OFFSET_EN.
module i2s_rx_multi #(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 18,
  parameter int CHANNELS    = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int DC_OFFSET   = 6212
) (
  input  logic                   clk_gen_fast,
  input  logic                   arstn,
  input  logic                   enable,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sel,
  input  logic                   sd,
  output logic [SAMPLE_BITS-1:0] m_tdata,
  output logic                   m_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] SAMP_B   = BW'(SAMPLE_BITS);

  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
    $error("BCLK_DIV must be even and >= 2");
  end
  if (SLOT_BITS < SAMPLE_BITS + 1) begin : g_bad_slot
    $error("SLOT_BITS must exceed SAMPLE_BITS");
  end
  if (CHANNELS < 1 || CHANNELS > 2) begin : g_bad_ch
    $error("CHANNELS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  // offsets beyond the full sample range would always saturate
  if (DC_OFFSET > (1 << SAMPLE_BITS) ||
      DC_OFFSET < -(1 << SAMPLE_BITS)) begin : g_bad_dc
    $error("DC_OFFSET out of range");
  end

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [BW-1:0] pos;
  logic          slot_r;
  logic          stb;
  logic          cap;
  logic          last;

  logic [SAMPLE_BITS-2:0] sh_q, sh_d;
  logic [SAMPLE_BITS-1:0] word_q;
  logic                   chan_q;
  logic                   done_q;
  logic                   bclk_q;
  logic                   lrclk_q;

  assign stb    = enable && (div_q == DIV_LAST);
  assign slot_r = bit_q >= SLOT_B;
  assign pos    = slot_r ? bit_q - SLOT_B : bit_q;
  assign cap    = stb && (pos != '0) && (pos <= SAMP_B);
  assign last   = stb && (pos == SAMP_B);

  always_comb begin
    div_d = '0;
    bit_d = '0;
    sh_d  = '0;
    if (enable) begin
      div_d = stb ? '0 : div_q + 1'b1;
      bit_d = bit_q;
      if (stb) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end
      sh_d = cap ? {sh_q[SAMPLE_BITS-3:0], sd} : sh_q;
    end
  end

  always_ff @(posedge clk_gen_fast or negedge arstn) begin
    if (!arstn) begin
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      chan_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bclk_q  <= div_d >= DIV_HALF;
      lrclk_q <= bit_d >= SLOT_B;
      done_q  <= last;
      if (last) begin
        word_q <= {sh_q, sd};
        chan_q <= slot_r;
      end
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
  assign sel   = 1'b0;

  logic [SAMPLE_BITS-1:0] val;

`ifdef I2S_RX_DC_OFFSET_EN
  localparam int MAXV = (1 << (SAMPLE_BITS - 1)) - 1;
  localparam int MINV = -(1 << (SAMPLE_BITS - 1));

  logic signed [31:0] sum;

  assign sum = $signed({{(32 - SAMPLE_BITS){word_q[SAMPLE_BITS-1]}}, word_q})
             + 32'(DC_OFFSET);

  always_comb begin
    val = sum[SAMPLE_BITS-1:0];
    if (sum > MAXV) begin
      val = SAMPLE_BITS'(MAXV);
    end else if (sum < MINV) begin
      val = SAMPLE_BITS'(MINV);
    end
  end
`else
  assign val = word_q;
`endif

  logic [SAMPLE_BITS:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q;
  logic [AW:0]          rd_q;
  logic                 push;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 wr;
  logic                 ovf_q;

  // mono build drops right-slot words here
  assign push  = done_q && ((CHANNELS == 2) || !chan_q);
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && m_tready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk_gen_fast or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wr_q[AW-1:0]] <= {chan_q, val};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign {m_tuser, m_tdata} = mem_q[rd_q[AW-1:0]];
  assign m_tvalid = !empty;
  assign overflow = ovf_q;

endmodule
